async_fifo_rd_stream: RTL
=========================

// Module: async_fifo_rd_stream
// PURPOSE
//  Read-side consumer for the async FIFO in the rd_clk domain. It drives the FIFO read port
//  (p_rd_en, 1-cycle registered p_rd_data, p_rd_empty) and re-presents the data as a
//  valid/ready stream with full throughput, optional packet framing (last every PKT_LEN
//  words), a delivered-word counter and a synchronous flush. Has no combinational path
//  from p_m_ready to p_fifo_rd_en.
// PARAMETERS
//  BITS       32  data width; equals the FIFO BITS
//  BUF_DEPTH  4   local prefetch buffer entries; power of two; >=3 gives 1 word/cycle
//  PKT_LEN    0   words per packet; 0 = framing off (p_m_last constant 0)
//  CNT_BITS   32  width of the delivered-word counter
// PORTS
//  rd_clk          in   1         single clock (the FIFO read clock)
//  rd_rst_n        in   1         asynchronous, active-low reset
//  p_fifo_rd_en    out  1         read request to the FIFO
//  p_fifo_rd_data  in   BITS      FIFO data; valid the cycle after an accepted read
//  p_fifo_rd_empty in   1         FIFO empty flag
//  p_m_valid       out  1         stream word available
//  p_m_ready       in   1         downstream accepts the word
//  p_m_data        out  BITS      head-of-buffer word
//  p_m_last        out  1         word is the last of its packet
//  p_flush         in   1         synchronous discard of buffered and in-flight words
//  p_words_out     out  CNT_BITS  count of words delivered (wraps)
// BEHAVIOUR
//  - Reset (async, rd_rst_n=0): p_fifo_rd_en=0, p_m_valid=0, p_m_data=0, p_m_last=0,
//    p_words_out=0. Buffer pointers, occupancy, in-flight flag and beat counter all clear.
//  - Issue: p_fifo_rd_en = !p_fifo_rd_empty && !p_flush && (occ + inflight < BUF_DEPTH).
//    occ and inflight are registered values only. inflight <= p_fifo_rd_en each cycle.
//  - Land: if inflight==1, capture p_fifo_rd_data at the buffer tail this cycle.
//    First word reaches p_m_valid two cycles after issue.
//  - Pop: a transfer occurs when p_m_valid && p_m_ready. It advances the head,
//    increments p_words_out (mod 2^CNT_BITS) and steps the beat counter.
//  - Simultaneous land and pop keeps occ unchanged. Buffer pointers are log2(BUF_DEPTH)+1
//    bits, wrap naturally, and use the MSB to tell full from empty.
//  - The credit rule guarantees no landing into a full buffer. The bench asserts
//    occ <= BUF_DEPTH.
//  - p_m_valid = (occ != 0). p_m_data is stable while valid && !ready (no retraction).
//  - Framing FSM, beat counter 0..PKT_LEN-1:
//    - p_m_last = (PKT_LEN != 0) && (beat == PKT_LEN-1).
//    - On a transfer with last=1, beat returns to 0; otherwise beat+1.
//  - Flush (p_flush=1 at an edge):
//    - occ clears, head=tail, beat clears, p_fifo_rd_en forced to 0 that cycle.
//    - A word landing in the same cycle is discarded.
//    - p_words_out is not cleared. p_m_valid=0 from the next cycle.
//    - A transfer in the flush cycle still counts.
//  - FIFO goes empty mid-stream: p_m_valid drops once the buffer drains. There is no bubble
//    beyond the 2-cycle refill latency after p_fifo_rd_empty deasserts.
//  - Reset mid-operation: immediate clear. The FIFO read side shares rd_rst_n, so an
//    in-flight word is lost by design.
// STRUCTURE
//  - fifo_pkg: BITS default, ptr_t/occ_t typedefs derived from BUF_DEPTH,
//    gray2bin/bin2gray functions shared with async_fifo.
//  - Sub-module rd_prefetch_buf: synchronous BUF_DEPTH x BITS register FIFO
//    (push, pop, clr, occ).
//  - Top holds the credit/issue logic, the beat FSM and the counter.
// TESTING
//  1. Reset: assert rd_rst_n=0 mid-clock -> all outputs 0 immediately, no p_fifo_rd_en
//     while low.
//  2. Stream: FIFO holds 0x1..0x10, p_m_ready=1 -> valid 2 cycles after first rd_en.
//     16 consecutive words 0x1..0x10 in order, then p_words_out=16.
//  3. Backpressure: 8 words, p_m_ready toggled 1/0 each cycle ->
//     - at most BUF_DEPTH+... never exceeded (occ<=4), rd_en stops at 4 buffered
//     - data held stable while stalled, no loss or duplication
//  4. Framing: PKT_LEN=4, 10 words -> p_m_last on words 4 and 8 only.
//     Beat counter reads 2 at end.
//  5. Flush: 3 words buffered plus 1 in flight, p_flush for 1 cycle ->
//     - p_m_valid=0 next cycle, in-flight word dropped, beat=0
//     - next delivered word is FIFO word 5
//  6. Empty toggling: p_fifo_rd_empty pulses 0/1 randomly for 200 words ->
//     scoreboard exact order; p_words_out=200; no read issued while empty.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side stream consumer.
package fifo_pkg;

  localparam int unsigned BITS_DEF      = 32;
  localparam int unsigned BUF_DEPTH_DEF = 4;
  localparam int unsigned PTR_W_DEF     = $clog2(BUF_DEPTH_DEF) + 1;

  typedef logic [PTR_W_DEF-1:0] ptr_t;
  typedef logic [PTR_W_DEF-1:0] occ_t;

  typedef enum logic [0:0] {
    FRM_BODY = 1'b0,
    FRM_LAST = 1'b1
  } frm_state_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int unsigned i = 1; i < 32; i++) begin
      b[31-i] = b[32-i] ^ g[31-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_prefetch_buf.sv
// Small synchronous register FIFO used as the read-side prefetch buffer.
module rd_prefetch_buf
  import fifo_pkg::*;
#(
  parameter int unsigned BITS  = BITS_DEF,
  parameter int unsigned DEPTH = BUF_DEPTH_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  logic [BITS-1:0]             data_i,
  input  logic                        pop_i,
  input  logic                        clr_i,
  output logic [BITS-1:0]             head_o,
  output logic [$clog2(DEPTH):0]      occ_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [BITS-1:0] mem_q [DEPTH];
  logic [AW:0]     head_q, head_d;
  logic [AW:0]     tail_q, tail_d;

  // Pointers carry one extra MSB so a full buffer (occ == DEPTH) differs from empty.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (clr_i) begin
      head_d = tail_q;
    end else begin
      if (push_i) tail_d = tail_q + 1'b1;
      if (pop_i)  head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (push_i && !clr_i) mem_q[tail_q[AW-1:0]] <= data_i;
    end
  end

  assign occ_o  = tail_q - head_q;
  assign head_o = mem_q[head_q[AW-1:0]];

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side consumer of the async FIFO: credit-based prefetch into a local
// buffer, re-presented as a valid/ready stream with optional packet framing.
module async_fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned BITS      = BITS_DEF,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int unsigned PKT_LEN   = 0,
  parameter int unsigned CNT_BITS  = 32
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  output logic                p_fifo_rd_en,
  input  logic [BITS-1:0]     p_fifo_rd_data,
  input  logic                p_fifo_rd_empty,
  output logic                p_m_valid,
  input  logic                p_m_ready,
  output logic [BITS-1:0]     p_m_data,
  output logic                p_m_last,
  input  logic                p_flush,
  output logic [CNT_BITS-1:0] p_words_out
);

  localparam int unsigned OCC_W  = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'((PKT_LEN > 0) ? PKT_LEN - 1 : 0);
  localparam logic [OCC_W:0]    CREDITS   = (OCC_W+1)'(BUF_DEPTH);
  localparam frm_state_e        FRM_INIT  = (PKT_LEN == 1) ? FRM_LAST : FRM_BODY;

  logic [OCC_W-1:0]    occ;
  logic [OCC_W:0]      credit_used;
  logic                inflight_q, inflight_d;
  logic                push, pop;
  logic [CNT_BITS-1:0] words_q, words_d;
  logic [BEAT_W-1:0]   beat_q;
  frm_state_e          frm_q;

  // Issue depends only on registered occupancy/in-flight state, never on
  // p_m_ready; gating with rd_rst_n keeps the read port quiet during reset.
  assign credit_used  = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
  assign p_fifo_rd_en = rd_rst_n && !p_fifo_rd_empty && !p_flush && (credit_used < CREDITS);

  assign p_m_valid   = (occ != '0);
  assign pop         = p_m_valid && p_m_ready;
  assign push        = inflight_q && !p_flush;
  assign p_m_last    = (PKT_LEN != 0) && (frm_q == FRM_LAST);
  assign p_words_out = words_q;

  always_comb begin
    inflight_d = p_fifo_rd_en;
    words_d    = words_q + CNT_BITS'(pop);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      inflight_q <= 1'b0;
      words_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      words_q    <= words_d;
    end
  end

  // Flush wins over a same-cycle transfer for the beat position, but the
  // transfer itself is still counted in words_q above.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      beat_q <= '0;
      frm_q  <= FRM_INIT;
    end else if (PKT_LEN != 0) begin
      if (p_flush) begin
        beat_q <= '0;
        frm_q  <= FRM_INIT;
      end else if (pop) begin
        case (frm_q)
          FRM_LAST: begin
            beat_q <= '0;
            frm_q  <= FRM_INIT;
          end
          FRM_BODY: begin
            beat_q <= beat_q + 1'b1;
            frm_q  <= ((beat_q + 1'b1) == BEAT_LAST) ? FRM_LAST : FRM_BODY;
          end
        endcase
      end
    end
  end

  rd_prefetch_buf #(
    .BITS  (BITS),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i  (rd_clk),
    .rst_ni (rd_rst_n),
    .push_i (push),
    .data_i (p_fifo_rd_data),
    .pop_i  (pop),
    .clr_i  (p_flush),
    .head_o (p_m_data),
    .occ_o  (occ)
  );

endmodule
